// File: rtl/aes_round_sequencer_if.sv
// Handshake, result and round-unit bundle for the iterative AES-128 sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface aes_round_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] aes_input;
    logic [127:0] aes_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] aes_output;
    logic         busy;
    logic [3:0]   round_cnt;
    logic [127:0] rnd_state;
    logic [127:0] rnd_key;
    logic [7:0]   rnd_rcon;
    logic         rnd_final;
    logic [127:0] rnd_next_state;
    logic [127:0] rnd_next_key;

    modport master (
        input  in_valid, aes_input, aes_key, out_ready, rnd_next_state, rnd_next_key,
        output in_ready, out_valid, aes_output, busy, round_cnt,
               rnd_state, rnd_key, rnd_rcon, rnd_final
    );

    modport slave (
        output in_valid, aes_input, aes_key, out_ready, rnd_next_state, rnd_next_key,
        input  in_ready, out_valid, aes_output, busy, round_cnt,
               rnd_state, rnd_key, rnd_rcon, rnd_final
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: drives a shared external single-round unit through
// the initial AddRoundKey and NUM_ROUNDS rounds, each round lasting RND_LAT cycles.
module aes_round_sequencer #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned RND_LAT    = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    aes_round_sequencer_if.master bus_io
);

    typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);
    localparam logic [1:0] SlotLast  = 2'(RND_LAT - 1);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [1:0]   slot_q, slot_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        slot_d  = slot_q;
        unique case (fsm_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    state_d = bus_io.aes_input ^ bus_io.aes_key;
                    key_d   = bus_io.aes_key;
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                    slot_d  = 2'd0;
                    fsm_d   = StRound;
                end
            end
            StRound: begin
                // Round-unit results are only trusted on the last cycle of a slot.
                if (slot_q == SlotLast) begin
                    state_d = bus_io.rnd_next_state;
                    key_d   = bus_io.rnd_next_key;
                    slot_d  = 2'd0;
                    if (round_q == LastRound) begin
                        fsm_d = StDone;
                    end else begin
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    fsm_d   = StIdle;
                    round_d = 4'd0;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            key_q   <= '0;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
            slot_q  <= 2'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            slot_q  <= slot_d;
        end
    end

    assign bus_io.in_ready   = rst_n && (fsm_q == StIdle);
    assign bus_io.out_valid  = (fsm_q == StDone);
    assign bus_io.aes_output = state_q;
    assign bus_io.busy       = (fsm_q == StRound);
    assign bus_io.round_cnt  = round_q;
    assign bus_io.rnd_state  = state_q;
    assign bus_io.rnd_key    = key_q;
    assign bus_io.rnd_rcon   = rcon_q;
    assign bus_io.rnd_final  = (fsm_q == StRound) && (round_q == LastRound);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (RND_LAT 1 and 3), each with a
// behavioural AES round unit, driven by a vector table plus directed sequences.
module tb_aes_round_sequencer;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_round_sequencer_if b1 ();
    aes_round_sequencer_if b3 ();

    aes_round_sequencer #(.NUM_ROUNDS(10), .RND_LAT(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (b1)
    );

    aes_round_sequencer #(.NUM_ROUNDS(10), .RND_LAT(3)) u_dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (b3)
    );

    logic         iv[2];
    logic         ordy[2];
    logic [127:0] pt[2];
    logic [127:0] ky[2];
    logic         ov[2];
    logic         ir[2];
    logic         bz[2];
    logic [3:0]   rc[2];
    logic [7:0]   rcon[2];
    logic [127:0] ao[2];

    assign b1.in_valid  = iv[0];
    assign b1.out_ready = ordy[0];
    assign b1.aes_input = pt[0];
    assign b1.aes_key   = ky[0];
    assign b3.in_valid  = iv[1];
    assign b3.out_ready = ordy[1];
    assign b3.aes_input = pt[1];
    assign b3.aes_key   = ky[1];

    assign ov[0] = b1.out_valid;   assign ov[1] = b3.out_valid;
    assign ir[0] = b1.in_ready;    assign ir[1] = b3.in_ready;
    assign bz[0] = b1.busy;        assign bz[1] = b3.busy;
    assign rc[0] = b1.round_cnt;   assign rc[1] = b3.round_cnt;
    assign rcon[0] = b1.rnd_rcon;  assign rcon[1] = b3.rnd_rcon;
    assign ao[0] = b1.aes_output;  assign ao[1] = b3.aes_output;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] rcon_seen[16];

    // ---------------- behavioural AES round model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, r, s, res;
        p = x; r = 8'h01;
        for (int i = 0; i < 7; i++) begin  // r = x^254 = multiplicative inverse
            p = gmul(p, p);
            r = gmul(r, p);
        end
        if (x == 8'h00) r = 8'h00;
        s = r; res = 8'h63 ^ r;
        for (int i = 0; i < 4; i++) begin
            s = {s[6:0], s[7]};
            res = res ^ s;
        end
        return res;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rcn);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t = {w3[23:0], w3[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcn, 24'h0};
        n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] nk,
                                               input logic fin);
        logic [7:0] a[16], t[16], m0, m1, m2, m3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = a[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                m0 = t[4*c]; m1 = t[4*c+1]; m2 = t[4*c+2]; m3 = t[4*c+3];
                t[4*c]   = gmul(8'h02, m0) ^ gmul(8'h03, m1) ^ m2 ^ m3;
                t[4*c+1] = m0 ^ gmul(8'h02, m1) ^ gmul(8'h03, m2) ^ m3;
                t[4*c+2] = m0 ^ m1 ^ gmul(8'h02, m2) ^ gmul(8'h03, m3);
                t[4*c+3] = gmul(8'h03, m0) ^ m1 ^ m2 ^ gmul(8'h02, m3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ nk;
    endfunction

    always_comb begin
        b1.rnd_next_key   = key_expand(b1.rnd_key, b1.rnd_rcon);
        b1.rnd_next_state = aes_round(b1.rnd_state, key_expand(b1.rnd_key, b1.rnd_rcon),
                                      b1.rnd_final);
    end

    // The RND_LAT=3 round unit only produces valid data on the slot-end cycle.
    logic [127:0] junk = '0;
    logic [127:0] nk3;
    int slot3 = 0;
    always @(negedge clk) junk <= {$urandom(), $urandom(), $urandom(), $urandom()};
    always @(posedge clk) begin
        if (!rst_n) slot3 <= 0;
        else if (b3.in_valid && b3.in_ready) slot3 <= 0;
        else if (b3.busy) slot3 <= (slot3 == 2) ? 0 : slot3 + 1;
    end
    always_comb begin
        nk3 = key_expand(b3.rnd_key, b3.rnd_rcon);
        if (slot3 == 2) begin
            b3.rnd_next_key   = nk3;
            b3.rnd_next_state = aes_round(b3.rnd_state, nk3, b3.rnd_final);
        end else begin
            b3.rnd_next_key   = ~junk;
            b3.rnd_next_state = junk;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_block(input int sel, input logic [127:0] k, input logic [127:0] p);
        int n;
        ky[sel] = k; pt[sel] = p; iv[sel] = 1'b1;
        n = 0;
        while (!ir[sel] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_accept", 128'(ir[sel]), 128'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int sel, output int cycles);
        cycles = 0;
        while (!ov[sel] && cycles < 200) begin
            if (bz[sel]) rcon_seen[rc[sel]] = rcon[sel];
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic wait_round(input int sel, input logic [3:0] r);
        int n;
        n = 0;
        while (rc[sel] != r && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_round", 128'(rc[sel]), 128'(r));
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[2];
    logic [7:0] rcon_exp[10];
    int cyc;
    int cnt_ov, cnt_bz;
    logic [127:0] held;

    initial begin
        vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        rcon_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; ordy[s] = 1'b0; pt[s] = '0; ky[s] = '0;
        end

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_low_lat1", 128'(ir[0]), 128'd0);
        check("rst_in_ready_low_lat3", 128'(ir[1]), 128'd0);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 128'(ov[0]), 128'd0);
        check("rst_busy", 128'(bz[0]), 128'd0);
        check("rst_round_cnt", 128'(rc[0]), 128'd0);
        check("rst_rcon", 128'(rcon[0]), 128'h01);
        check("rst_aes_output", ao[0], 128'd0);
        check("rst_final", 128'(b1.rnd_final), 128'd0);
        check("idle_in_ready", 128'(ir[0]), 128'd1);

        // Table-driven blocks, consumer always ready
        ordy[0] = 1'b1;
        for (int v = 0; v < 2; v++) begin
            start_block(0, vecs[v].key, vecs[v].pt);
            iv[0] = 1'b0; pt[0] = ~vecs[v].pt; ky[0] = ~vecs[v].key;
            wait_done(0, cyc);
            check($sformatf("vec%0d_latency", v), 128'(cyc), 128'd10);
            check($sformatf("vec%0d_ct", v), ao[0], vecs[v].ct);
            check($sformatf("vec%0d_final_in_done", v), 128'(b1.rnd_final), 128'd0);
            if (v == 0)
                for (int r = 1; r <= 10; r++)
                    check($sformatf("rcon_round%0d", r), 128'(rcon_seen[r]), 128'(rcon_exp[r-1]));
            @(posedge clk); #1;
            check($sformatf("vec%0d_ov_drop", v), 128'(ov[0]), 128'd0);
            check($sformatf("vec%0d_ready_back", v), 128'(ir[0]), 128'd1);
            check($sformatf("vec%0d_round_zero", v), 128'(rc[0]), 128'd0);
        end

        // Backpressure
        ordy[0] = 1'b0;
        start_block(0, vecs[0].key, vecs[0].pt);
        iv[0] = 1'b0;
        wait_done(0, cyc);
        held = ao[0];
        check("bp_ct", held, vecs[0].ct);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_ov_held", 128'(ov[0]), 128'd1);
            check("bp_output_stable", ao[0], held);
            check("bp_in_ready_low", 128'(ir[0]), 128'd0);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ov", 128'(ov[0]), 128'd0);
        check("bp_release_ready", 128'(ir[0]), 128'd1);
        check("bp_release_round", 128'(rc[0]), 128'd0);

        // in_valid with a different block during rounds 3..6 is ignored
        start_block(0, vecs[0].key, vecs[0].pt);
        iv[0] = 1'b0;
        wait_round(0, 4'd3);
        iv[0] = 1'b1; pt[0] = vecs[1].pt; ky[0] = vecs[1].key;
        wait_round(0, 4'd7);
        iv[0] = 1'b0;
        wait_done(0, cyc);
        check("ignore_ct", ao[0], vecs[0].ct);
        cnt_ov = 0; cnt_bz = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (ov[0]) cnt_ov++;
            if (bz[0]) cnt_bz++;
        end
        check("ignore_no_second_out", 128'(cnt_ov), 128'd0);
        check("ignore_no_second_run", 128'(cnt_bz), 128'd0);

        // Reset mid-run at round 5
        start_block(0, vecs[0].key, vecs[0].pt);
        iv[0] = 1'b0;
        wait_round(0, 4'd5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_ov", 128'(ov[0]), 128'd0);
        check("midrst_busy", 128'(bz[0]), 128'd0);
        check("midrst_round", 128'(rc[0]), 128'd0);
        check("midrst_ready", 128'(ir[0]), 128'd1);
        cnt_ov = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (ov[0]) cnt_ov++;
        end
        check("midrst_no_out", 128'(cnt_ov), 128'd0);
        start_block(0, vecs[1].key, vecs[1].pt);
        iv[0] = 1'b0;
        wait_done(0, cyc);
        check("midrst_new_latency", 128'(cyc), 128'd10);
        check("midrst_new_ct", ao[0], vecs[1].ct);
        @(posedge clk); #1;

        // RND_LAT = 3 instance, garbage on round-unit outputs outside slot end
        ordy[1] = 1'b1;
        start_block(1, vecs[0].key, vecs[0].pt);
        iv[1] = 1'b0;
        wait_done(1, cyc);
        check("lat3_latency", 128'(cyc), 128'd30);
        check("lat3_ct", ao[1], vecs[0].ct);
        for (int r = 1; r <= 10; r++)
            check($sformatf("lat3_rcon_round%0d", r), 128'(rcon_seen[r]), 128'(rcon_exp[r-1]));

        // Back-to-back with in_valid held high
        start_block(0, vecs[0].key, vecs[0].pt);
        pt[0] = vecs[1].pt; ky[0] = vecs[1].key;
        wait_done(0, cyc);
        check("b2b_first_latency", 128'(cyc), 128'd10);
        check("b2b_first_ct", ao[0], vecs[0].ct);
        @(posedge clk); #1;
        check("b2b_ov_drop", 128'(ov[0]), 128'd0);
        check("b2b_ready", 128'(ir[0]), 128'd1);
        @(posedge clk); #1;
        check("b2b_second_accept_busy", 128'(bz[0]), 128'd1);
        check("b2b_second_accept_round", 128'(rc[0]), 128'd1);
        iv[0] = 1'b0;
        wait_done(0, cyc);
        check("b2b_second_latency", 128'(cyc), 128'd10);
        check("b2b_second_ct", ao[0], vecs[1].ct);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller. Sequences a shared single-round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey plus one key-schedule step) through the initial AddRoundKey and 10 rounds.
- Owns the state and round-key registers, the round counter, Rcon generation, and the input/output valid/ready handshakes.
- Provides a low-area alternative to a fully unrolled AES top, with the same aes_input/aes_key/aes_output data contract.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds (AES-128). Counter logic must support 1..15.
- RND_LAT, 1, cycles the external round unit needs per round. Legal range 1..4. Results are sampled on the last cycle of each round slot.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  aes_input/aes_key valid
- in_ready  out  1  sequencer can accept a block
- aes_input  in  128  plaintext block
- aes_key  in  128  cipher key
- out_valid  out  1  aes_output holds ciphertext
- out_ready  in  1  consumer accepts ciphertext
- aes_output  out  128  ciphertext (state register)
- busy  out  1  encryption in progress (ROUND state)
- round_cnt  out  4  current round number, 0 when idle
- rnd_state  out  128  state fed to round unit (= state register)
- rnd_key  out  128  previous round key fed to round unit (= key register)
- rnd_rcon  out  8  Rcon for the key-schedule step of the current round
- rnd_final  out  1  high in the final round; round unit must skip MixColumns
- rnd_next_state  in  128  round-unit result: AddRoundKey(MixCol?(ShiftRows(SubBytes(rnd_state))), rnd_next_key)
- rnd_next_key  in  128  next round key expanded from rnd_key with rnd_rcon

Behaviour:
- One clock domain (clk). Reset is synchronous, active-low: rst_n sampled low at a rising edge of clk forces reset.
- Reset values:
  - FSM = IDLE.
  - state_reg, key_reg, aes_output = 0.
  - round_cnt = 0, rnd_rcon = 8'h01, slot counter = 0.
  - out_valid = 0, busy = 0, rnd_final = 0.
  - in_ready is forced to 0 while rst_n is low; otherwise in_ready = (FSM == IDLE).
- IDLE: on an edge with in_valid && in_ready:
  - state_reg <= aes_input ^ aes_key; key_reg <= aes_key.
  - round_cnt <= 1, rcon <= 8'h01, slot counter <= 0.
  - FSM -> ROUND.
- ROUND: the slot counter counts 0..RND_LAT-1. On the edge where slot == RND_LAT-1:
  - state_reg <= rnd_next_state; key_reg <= rnd_next_key; slot <= 0.
  - If round_cnt == NUM_ROUNDS: FSM -> DONE and round_cnt holds.
  - Otherwise round_cnt++ and rcon <= xtime(rcon), where xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - Required Rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- rnd_final = (FSM == ROUND) && (round_cnt == NUM_ROUNDS).
- busy = (FSM == ROUND).
- DONE:
  - out_valid = 1; aes_output = state_reg, held stable while out_ready is low.
  - On an edge with out_ready high: FSM -> IDLE, round_cnt <= 0, out_valid drops the next cycle.
  - in_ready stays 0 in DONE; there is no same-cycle accept/emit.
- Latency: aes_output/out_valid are asserted exactly NUM_ROUNDS*RND_LAT cycles after the input-handshake edge (10 cycles at defaults).
- in_valid outside IDLE is ignored. aes_input/aes_key are sampled only at the handshake edge; later changes do not affect the block in flight.
- rnd_next_state/rnd_next_key are sampled only on the slot-end edge; their values at other times are don't-care.
- Reset mid-operation (any state): all registers return to their reset values at that edge and the block in flight is discarded. No out_valid pulse is produced for it.
- aes_output in IDLE/ROUND shows state_reg and is not meaningful while out_valid = 0.

Test Plan:
- Bench round unit: a behavioural single-round model (SubBytes, ShiftRows, MixColumns skipped on rnd_final, key expansion with rnd_rcon).
- FIPS-197 App. B at defaults: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_valid exactly 10 cycles after the handshake, aes_output = 3925841d02dc09fbdc118597196a0b32. Also check rnd_rcon per round = 01,02,04,08,10,20,40,80,1B,36.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid -> out_valid stays 1, aes_output constant, in_ready = 0. Raise out_ready -> next cycle out_valid = 0, in_ready = 1, round_cnt = 0.
- Ignored input: pulse in_valid with a different block during rounds 3..6 -> result is still 3925841d02dc09fbdc118597196a0b32 and no second output appears.
- Reset mid-run: drive rst_n = 0 for one edge at round_cnt = 5 -> next cycle out_valid = 0, busy = 0, round_cnt = 0, in_ready = 1. A new FIPS-197 C.1 block (key 000102…0f, pt 00112233…eeff) then yields 69c4e0d86a7b0430d8cdb78070b4c55a.
- RND_LAT = 3: App. B vector -> out_valid exactly 30 cycles after the handshake, same ciphertext. The round unit drives garbage on rnd_next_* outside slot-end cycles, with no effect on the result.
- Back-to-back: keep in_valid high for two blocks with out_ready tied high -> second accept occurs one cycle after out_valid drops, and both ciphertexts are correct.
